serializer_feed_arbiter: RTL

- Round-robin arbiter that shares one 64-to-8 serializer input FIFO among NUM_REQ 64-bit word producers.
- Grants one requester at a time for a burst of up to MAX_BURST words, then re-arbitrates.
- Drives the FIFO write side: strobe, 64-bit data and a source tag.
- Honours the FIFO full flag with zero-latency backpressure, so no word is ever presented while the FIFO is full.

---
 rtl/serializer_arb_pkg.sv | 15 +
 rtl/serializer_feed_arbiter_rr_pick.sv | 33 +++
 rtl/serializer_feed_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/serializer_arb_pkg.sv
// Shared types and defaults for the serializer feed arbiter.
//   arb_state_t    : arbiter FSM state (IDLE / BURST)
//   *_DEF          : default parameter values used by the top level
package serializer_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int NUM_REQ_DEF   = 4;
  localparam int MAX_BURST_DEF = 8;
  localparam int DATA_W_DEF    = 64;

endpackage

// File: rtl/serializer_feed_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i  : request vector
//   last_i : index of the previously released requester
//   pick_o : first requester with req set, searching from last_i+1 (wrapping)
//   any_o  : at least one request is set
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  output logic [ID_W-1:0]    pick_o,
  output logic               any_o
);

  logic [ID_W-1:0] idx;

  // Offsets 1..NUM_REQ: the last granted requester is considered last, so a
  // lone requester still wins.
  always_comb begin
    pick_o = '0;
    any_o  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_i) + k) % NUM_REQ);
      if (!any_o && req_i[idx]) begin
        any_o  = 1'b1;
        pick_o = idx;
      end
    end
  end

endmodule

// File: rtl/serializer_feed_arbiter.sv
// Round-robin arbiter feeding one serializer input FIFO from NUM_REQ word
// producers. A grant lasts up to MAX_BURST words and is released on a last
// word, a full burst, or a valid bubble from the granted requester.
//   clk, reset_n            : clock, async active-low reset
//   req_valid/data/last     : per-requester word stream (data packed, i at [i*DATA_W +: DATA_W])
//   req_ready               : per-requester accept (combinational from fifo_full)
//   fifo_full               : FIFO full flag, zero-latency backpressure
//   fifo_strobe, fifo_data  : FIFO write side
//   grant_id, busy          : current grant and BURST indication
module serializer_feed_arbiter
  import serializer_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_strobe,
  output logic [DATA_W-1:0]         fifo_data,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;

  logic [DATA_W-1:0] word [NUM_REQ];
  logic [ID_W-1:0]   pick;
  logic              pick_any;
  logic              in_burst;
  logic              g_valid, g_last, xfer;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .pick_o (pick),
    .any_o  (pick_any)
  );

  assign in_burst = (state_q == BURST);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign word[g]      = req_data[g*DATA_W +: DATA_W];
    assign req_ready[g] = in_burst && (grant_q == ID_W'(g)) && !fifo_full;
  end

  assign g_valid = req_valid[grant_q];
  assign g_last  = req_last[grant_q];
  assign xfer    = in_burst && g_valid && !fifo_full;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BURST;
          grant_d = pick;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (!g_valid) begin
          // Bubble from the granted requester gives up the grant, even when
          // the FIFO is full at the same time.
          state_d = IDLE;
          last_d  = grant_q;
        end else if (xfer) begin
          cnt_d = cnt_inc;
          if (g_last || (cnt_inc == CNT_W'(MAX_BURST))) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fifo_strobe = xfer;
  assign fifo_data   = word[grant_q];
  assign grant_id    = grant_q;
  assign busy        = in_burst;

endmodule
